video_timing_analyzer: RTL and testbench

Receive-side checker for the parallel RGB video bus (HS, VS, DE, R, G, B) driven by `image_generator` toward the OLED SVGA060 panel path. It samples the incoming stream and measures the frame geometry: active pixels per line, active lines, total clocks per line and total lines per frame. It declares lock after a configurable number of identical consecutive frames and flags line-length and geometry errors. It sits in parallel with the panel interface as an on-chip monitor; its outputs are readable by the bench and by debug logic.

---
 rtl/video_analyzer_pkg.sv | 37 +++
 rtl/sync_edge_detect.sv | 27 ++
 rtl/video_timing_analyzer.sv | 225 ++++++++++++++++++++++
 tb/tb_video_timing_analyzer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_analyzer_pkg.sv
// video_analyzer_pkg: shared state, geometry and CRC definitions
// for the video_timing_analyzer receive-side monitor.
package video_analyzer_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        TRACK   = 2'd2
    } state_t;

    // Fields sized for the widest supported counter (CNT_W <= GEOM_W).
    localparam int GEOM_W = 16;

    typedef struct packed {
        logic [GEOM_W-1:0] h_act;
        logic [GEOM_W-1:0] v_act;
        logic [GEOM_W-1:0] h_tot;
        logic [GEOM_W-1:0] v_tot;
    } geom_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    function automatic logic [15:0] crc16_step(
        input logic [15:0] crc,
        input logic [23:0] data
    );
        logic [15:0] c;
        c = crc;
        for (int i = 23; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: registers a sync input, normalises it to
// active-high and emits a one-clock pulse on its rising edge.
module sync_edge_detect #(
    parameter int ACTIVE_HIGH = 0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_edge
);

    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= (ACTIVE_HIGH != 0) ? i_sig : ~i_sig;
            r_prev <= r_sync;
        end
    end

    assign o_edge = r_sync & ~r_prev;

endmodule

// File: rtl/video_timing_analyzer.sv
// video_timing_analyzer: passive monitor measuring frame geometry and lock.
// Frame CRC over active pixels is built when VIDEO_TIMING_ANALYZER_CRC_EN is defined.
module video_timing_analyzer
    import video_analyzer_pkg::*;
#(
    parameter int CNT_W          = 12,
    parameter int LOCK_FRAMES    = 3,
    parameter int HS_ACTIVE_HIGH = 0,
    parameter int VS_ACTIVE_HIGH = 0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             HS,
    input  logic             VS,
    input  logic             DE,
    input  logic [7:0]       R,
    input  logic [7:0]       G,
    input  logic [7:0]       B,
    output logic [CNT_W-1:0] HActive,
    output logic [CNT_W-1:0] VActive,
    output logic [CNT_W-1:0] HTotal,
    output logic [CNT_W-1:0] VTotal,
    output logic             FrameDone,
    output logic             Locked,
    output logic             ErrLine,
    output logic             ErrGeom,
    output logic [15:0]      FrameCrc
);

    localparam logic [3:0] LOCK_M1 = 4'(LOCK_FRAMES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic w_hs_edge;
    logic w_vs_edge;

    sync_edge_detect #(.ACTIVE_HIGH(HS_ACTIVE_HIGH)) u_hs_edge (
        .i_clk   (Clock),
        .i_rst_n (Reset),
        .i_sig   (HS),
        .o_edge  (w_hs_edge)
    );

    sync_edge_detect #(.ACTIVE_HIGH(VS_ACTIVE_HIGH)) u_vs_edge (
        .i_clk   (Clock),
        .i_rst_n (Reset),
        .i_sig   (VS),
        .o_edge  (w_vs_edge)
    );

    logic             r_de;
    logic [CNT_W-1:0] r_pix_cnt;
    logic [CNT_W-1:0] r_de_cnt;
    logic [CNT_W-1:0] r_line_total;
    logic [CNT_W-1:0] r_ref_de;
    logic [CNT_W-1:0] r_line_cnt;
    logic [CNT_W-1:0] r_act_lines;
    logic             r_line_err;
    geom_t            r_cand;
    logic             r_cand_err;
    logic             r_pend;

    state_t           r_state;
    geom_t            r_pub;
    logic             r_have_prev;
    logic [3:0]       r_match_cnt;
    logic             r_fdone;
    logic             r_locked;
    logic             r_err_line;
    logic             r_err_geom;

    logic [CNT_W-1:0] w_line_de;
    logic [CNT_W-1:0] w_ref_n;
    logic             w_err_n;
    logic [CNT_W-1:0] w_lcnt_n;
    logic [CNT_W-1:0] w_act_n;
    logic [CNT_W-1:0] w_ltot_n;
    geom_t            w_cand;
    logic             w_match;
    logic [3:0]       w_match_n;

    // Line close is folded in first so a coincident VS sees the closing line.
    assign w_line_de = r_de ? sat_inc(r_de_cnt) : r_de_cnt;
    assign w_ref_n   = (w_hs_edge && r_ref_de == '0) ? w_line_de : r_ref_de;
    assign w_err_n   = r_line_err | (w_hs_edge && w_line_de != '0
                       && r_ref_de != '0 && w_line_de != r_ref_de);
    assign w_lcnt_n  = w_hs_edge ? sat_inc(r_line_cnt) : r_line_cnt;
    assign w_act_n   = (w_hs_edge && w_line_de != '0) ? sat_inc(r_act_lines)
                                                      : r_act_lines;
    assign w_ltot_n  = w_hs_edge ? sat_inc(r_pix_cnt) : r_line_total;

    assign w_cand.h_act = GEOM_W'(w_ref_n);
    assign w_cand.v_act = GEOM_W'(w_act_n);
    assign w_cand.h_tot = GEOM_W'(w_ltot_n);
    assign w_cand.v_tot = GEOM_W'(w_lcnt_n);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_de         <= 1'b0;
            r_pix_cnt    <= '0;
            r_de_cnt     <= '0;
            r_line_total <= '0;
            r_ref_de     <= '0;
            r_line_cnt   <= '0;
            r_act_lines  <= '0;
            r_line_err   <= 1'b0;
            r_cand       <= '0;
            r_cand_err   <= 1'b0;
            r_pend       <= 1'b0;
        end else begin
            r_de         <= DE;
            r_pix_cnt    <= w_hs_edge ? '0 : sat_inc(r_pix_cnt);
            r_de_cnt     <= w_hs_edge ? '0 : w_line_de;
            r_line_total <= w_ltot_n;
            r_pend       <= w_vs_edge && (r_state != SEARCH);
            if (w_vs_edge) begin
                r_ref_de    <= '0;
                r_line_cnt  <= '0;
                r_act_lines <= '0;
                r_line_err  <= 1'b0;
                r_cand      <= w_cand;
                r_cand_err  <= w_err_n;
            end else begin
                r_ref_de    <= w_ref_n;
                r_line_cnt  <= w_lcnt_n;
                r_act_lines <= w_act_n;
                r_line_err  <= w_err_n;
            end
        end
    end

    assign w_match   = r_have_prev && (r_cand == r_pub);
    assign w_match_n = !w_match ? 4'd0 :
                       (&r_match_cnt) ? r_match_cnt : r_match_cnt + 4'd1;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state     <= SEARCH;
            r_pub       <= '0;
            r_have_prev <= 1'b0;
            r_match_cnt <= '0;
            r_fdone     <= 1'b0;
            r_locked    <= 1'b0;
            r_err_line  <= 1'b0;
            r_err_geom  <= 1'b0;
        end else begin
            r_fdone <= 1'b0;
            if (r_pend) begin
                r_pub       <= r_cand;
                r_fdone     <= 1'b1;
                r_have_prev <= 1'b1;
                if (r_cand_err) r_err_line <= 1'b1;
            end
            unique case (r_state)
                SEARCH: begin
                    if (w_vs_edge) r_state <= MEASURE;
                end
                MEASURE: begin
                    if (r_pend) begin
                        r_match_cnt <= w_match_n;
                        if (w_match_n >= LOCK_M1) begin
                            r_state  <= TRACK;
                            r_locked <= 1'b1;
                        end
                    end
                end
                TRACK: begin
                    if (r_pend) begin
                        if (w_match) begin
                            r_match_cnt <= w_match_n;
                        end else begin
                            r_match_cnt <= '0;
                            r_locked    <= 1'b0;
                            r_err_geom  <= 1'b1;
                            r_state     <= MEASURE;
                        end
                    end
                end
                default: r_state <= SEARCH;
            endcase
        end
    end

    assign HActive   = r_pub.h_act[CNT_W-1:0];
    assign VActive   = r_pub.v_act[CNT_W-1:0];
    assign HTotal    = r_pub.h_tot[CNT_W-1:0];
    assign VTotal    = r_pub.v_tot[CNT_W-1:0];
    assign FrameDone = r_fdone;
    assign Locked    = r_locked;
    assign ErrLine   = r_err_line;
    assign ErrGeom   = r_err_geom;

`ifdef VIDEO_TIMING_ANALYZER_CRC_EN
    logic [23:0] r_rgb;
    logic [15:0] r_crc;
    logic [15:0] r_cand_crc;
    logic [15:0] r_crc_pub;
    logic [15:0] w_crc_n;

    assign w_crc_n = r_de ? crc16_step(r_crc, r_rgb) : r_crc;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_rgb      <= '0;
            r_crc      <= CRC_INIT;
            r_cand_crc <= '0;
            r_crc_pub  <= '0;
        end else begin
            r_rgb <= {R, G, B};
            r_crc <= w_vs_edge ? CRC_INIT : w_crc_n;
            if (w_vs_edge) r_cand_crc <= w_crc_n;
            if (r_pend)    r_crc_pub  <= r_cand_crc;
        end
    end

    assign FrameCrc = r_crc_pub;
`else
    logic w_unused_rgb;
    assign w_unused_rgb = ^{R, G, B};
    assign FrameCrc     = '0;
`endif

endmodule

// File: tb/tb_video_timing_analyzer.sv
// tb_video_timing_analyzer: randomized frame stream with a frame-level
// reference model feeding a scoreboard checked on every FrameDone.
`timescale 1ns/1ps
module tb_video_timing_analyzer;

    localparam int CW  = 6;
    localparam int LF  = 3;
    localparam int SAT = (1 << CW) - 1;
    localparam int HSW = 3;
    localparam int VSW = 2;
    localparam int DST = 5;
    localparam int VST = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          hs    = 1'b1;
    logic          vs    = 1'b1;
    logic          de    = 1'b0;
    logic [7:0]    r     = 8'h0;
    logic [7:0]    g     = 8'h0;
    logic [7:0]    b     = 8'h0;
    logic [CW-1:0] ha_o, va_o, ht_o, vt_o;
    logic          fd, lk, el, eg;
    logic [15:0]   crc_o;

    video_timing_analyzer #(
        .CNT_W(CW), .LOCK_FRAMES(LF),
        .HS_ACTIVE_HIGH(0), .VS_ACTIVE_HIGH(0)
    ) dut (
        .Clock(clk), .Reset(rst_n),
        .HS(hs), .VS(vs), .DE(de),
        .R(r), .G(g), .B(b),
        .HActive(ha_o), .VActive(va_o), .HTotal(ht_o), .VTotal(vt_o),
        .FrameDone(fd), .Locked(lk), .ErrLine(el), .ErrGeom(eg),
        .FrameCrc(crc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ha; int va; int ht; int vt;
        int lk; int el; int eg; int crc; int at;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic fd_q  = 1'b0;

    // frame-level model state
    int          m_have = 0, m_prev_ok = 0, run = 0;
    int          m_lock = 0, m_el = 0, m_eg = 0;
    int          p_ha, p_va, p_ht, p_vt;
    int          f_ha = 0, f_va = 0, f_err = 0, f_ht = 0, f_vt = 0;
    logic [15:0] f_crc = 16'hFFFF;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [23:0] w);
        logic [15:0] x;
        logic        fb;
        x = c;
        for (int i = 0; i < 24; i++) begin
            fb = x[15] ^ w[23-i];
            x  = {x[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return x;
    endfunction

    task automatic close_frame();
        exp_t e;
        int   same;
        if (m_have != 0) begin
            e.ha = sat(f_ha); e.va = sat(f_va);
            e.ht = sat(f_ht); e.vt = sat(f_vt);
            same = (m_prev_ok != 0) && e.ha == p_ha && e.va == p_va
                   && e.ht == p_ht && e.vt == p_vt;
            if (m_lock != 0 && same == 0) begin
                m_lock = 0; m_eg = 1; run = 1;
            end else begin
                run = (same != 0) ? run + 1 : 1;
                if (run >= LF) m_lock = 1;
            end
            if (f_err != 0) m_el = 1;
            p_ha = e.ha; p_va = e.va; p_ht = e.ht; p_vt = e.vt;
            m_prev_ok = 1;
            e.lk = m_lock; e.el = m_el; e.eg = m_eg;
`ifdef VIDEO_TIMING_ANALYZER_CRC_EN
            e.crc = int'(f_crc);
`else
            e.crc = 0;
`endif
            e.at = cyc + 3;
            q.push_back(e);
        end
        m_have = 1;
        f_ha = 0; f_va = 0; f_err = 0; f_crc = 16'hFFFF;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_hact"}, int'(ha_o), 0);
        chk({tag, "_vact"}, int'(va_o), 0);
        chk({tag, "_htot"}, int'(ht_o), 0);
        chk({tag, "_vtot"}, int'(vt_o), 0);
        chk({tag, "_fdone"}, int'(fd), 0);
        chk({tag, "_locked"}, int'(lk), 0);
        chk({tag, "_errs"}, int'({el, eg}), 0);
        chk({tag, "_crc"}, int'(crc_o), 0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #0.5 check_zero("midrst");
        #0.5 rst_n = 1'b1;
        m_have = 0; m_prev_ok = 0; run = 0;
        m_lock = 0; m_el = 0; m_eg = 0;
    endtask

    task automatic frame(input int H, input int V, input int ha, input int va,
                         input int badl, input int zero, input int rstl, input int nl);
        for (int l = 0; l < nl; l++) begin
            int nde;
            nde = (l >= VST && l < VST + va) ? ha + ((l == badl) ? 1 : 0) : 0;
            for (int p = 0; p < H; p++) begin
                @(posedge clk);
                #1;
                if (l == 0 && p == 0) close_frame();
                hs = (p < HSW) ? 1'b0 : 1'b1;
                vs = (l < VSW) ? 1'b0 : 1'b1;
                de = (p >= DST && p < DST + nde);
                {r, g, b} = (zero != 0) ? 24'h0 : 24'($urandom);
                if (de) f_crc = crc_word(f_crc, {r, g, b});
                if (l == rstl && p == 7) do_reset();
            end
            if (nde != 0) begin
                if (f_ha == 0) f_ha = nde;
                else if (nde != f_ha) f_err = 1;
                f_va++;
            end
        end
        f_ht = H;
        f_vt = V;
    endtask

    always @(negedge clk) begin
        if (fd) begin
            chk("fd_pulse", int'(fd_q), 0);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL fd_unexpected: FrameDone at cycle %0d, none expected", cyc);
            end else begin
                me = q.pop_front();
                chk("latency", cyc, me.at);
                chk("hactive", int'(ha_o), me.ha);
                chk("vactive", int'(va_o), me.va);
                chk("htotal", int'(ht_o), me.ht);
                chk("vtotal", int'(vt_o), me.vt);
                chk("locked", int'(lk), me.lk);
                chk("errline", int'(el), me.el);
                chk("errgeom", int'(eg), me.eg);
                chk("framecrc", int'(crc_o), me.crc);
            end
        end
        fd_q <= fd;
    end

    initial begin
        int aH, aV, aha, ava, bH, bV, bha, bva, cV, cva;
        aH  = $urandom_range(24, 40);
        aV  = $urandom_range(10, 16);
        aha = $urandom_range(8, aH - DST - 2);
        ava = $urandom_range(4, aV - VST - 1);
        bH  = $urandom_range(41, 56);
        bV  = $urandom_range(10, 16);
        bha = $urandom_range(8, bH - DST - 2);
        bva = $urandom_range(4, bV - VST - 1);
        cV  = $urandom_range(10, 16);
        cva = $urandom_range(4, cV - VST - 1);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_zero("reset");
        repeat (4) @(posedge clk);

        repeat (5) frame(aH, aV, aha, ava, -1, 0, -1, aV);
        frame(aH, aV, aha, ava, VST + 1, 0, -1, aV);
        frame(aH, aV, aha, ava, -1, 0, -1, aV);
        repeat (4) frame(bH, bV, bha, bva, -1, 0, -1, bV);
        // lines of 75 clocks with 65 active pixels saturate the 6-bit counters
        repeat (3) frame(75, cV, 65, cva, -1, 0, -1, cV);
        frame(aH, aV, aha, ava, -1, 0, 5, aV);
        repeat (2) frame(aH, aV, aha, ava, -1, 1, -1, aV);
        repeat (2) frame(aH, aV, aha, ava, -1, 0, -1, aV);
        frame(aH, aV, aha, ava, -1, 0, -1, 1);
        repeat (10) @(posedge clk);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL missing_fd: %0d frames pending, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
